// File: rtl/sos_pkg.sv
// Shared types and constants for the biquad (SOS) section and its input pacing stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sos_pkg;

    localparam int SOS_DATA_W          = 24;
    localparam int SOS_MULT_PIPE       = 13;
    localparam int SOS_MIN_GAP_DEFAULT = 16;

    typedef logic signed [SOS_DATA_W-1:0] sos_sample_t;

endpackage

// File: rtl/sos_input_scheduler_if.sv
// Upstream sample channel into the SOS input scheduler (valid/ready, 24-bit signed).
// Latency: n/a (wiring only).
// Backpressure: slave drops s_ready when it cannot take a sample; master holds s_data/s_valid.
interface sos_input_scheduler_if;
    import sos_pkg::*;

    logic        s_valid;
    logic        s_ready;
    sos_sample_t s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sos_sync_fifo.sv
// Sample FIFO for the SOS input scheduler: storage, wrapping pointers, explicit occupancy.
// Latency: a pushed sample is visible at head one cycle after the push edge.
// Backpressure: none internally; caller must not push when full or pop when empty.
module sos_sync_fifo
    import sos_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  sos_sample_t            push_data,
    input  logic                   pop,
    input  logic                   flush,
    output sos_sample_t            head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    sos_sample_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap at DEPTH naturally; level is kept separately so full/empty never alias.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sos_input_scheduler.sv
// Paces samples into the SOS section: at most one issue per MIN_GAP cycles (optional SOS_IN_SCALE_EN input scaling).
// Latency: 2 cycles from accept to data_valid_out when idle (issue edge follows accept edge).
// Backpressure: s_ready drops when DEPTH samples are buffered or during flush; full uses registered level only.
module sos_input_scheduler
    import sos_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int MIN_GAP     = SOS_MIN_GAP_DEFAULT,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sos_input_scheduler_if.slave   s_if,
    input  logic                   enable,
    input  logic                   flush,
    output logic                   data_valid_out,
    output sos_sample_t            data_out,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    localparam int LVL_W      = $clog2(DEPTH) + 1;
    localparam int GAP_W      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sos_input_scheduler: DEPTH must be a power of 2 and at least 2");
    end
    if (SCALE_SHIFT < 1 || SCALE_SHIFT > 8) begin : g_bad_scale_shift
        $error("sos_input_scheduler: SCALE_SHIFT must be in 1..8");
    end
    if (MIN_GAP < 1) begin : g_bad_min_gap
        $error("sos_input_scheduler: MIN_GAP must be at least 1");
    end

    logic             push;
    logic             issue;
    logic [GAP_W-1:0] gap_cnt;
    sos_sample_t      head;
    sos_sample_t      issue_data;

    // Ready looks only at registered occupancy and flush, never at s_valid.
    assign s_if.s_ready = (level != LVL_W'(DEPTH)) && !flush;
    assign push         = s_if.s_valid && s_if.s_ready;
    assign issue        = enable && (level != '0) && (gap_cnt == '0) && !flush;
    assign busy         = (level != '0) || (gap_cnt != '0);

    sos_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (s_if.s_data),
        .pop       (issue),
        .flush     (flush),
        .head      (head),
        .level     (level)
    );

`ifdef SOS_IN_SCALE_EN
    localparam int ROUND_ADD = 1 << (SCALE_SHIFT - 1);

    logic signed [SOS_DATA_W:0] head_ext;
    logic signed [SOS_DATA_W:0] head_rnd;
    logic signed [SOS_DATA_W:0] head_shr;

    // Round half up in 25 bits; after a shift of at least 1 the result always fits 24 bits.
    always_comb begin
        head_ext   = {head[SOS_DATA_W-1], head};
        head_rnd   = head_ext + (SOS_DATA_W+1)'(ROUND_ADD);
        head_shr   = head_rnd >>> SCALE_SHIFT;
        issue_data = head_shr[SOS_DATA_W-1:0];
    end
`else
    // Bit-exact pass-through of the head sample.
    always_comb begin
        issue_data = head;
    end
`endif

    // Issue strobe, held output sample and gap counter; flush leaves the counter and data alone
    // so a sample already inside the SOS recursion stays protected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_valid_out <= 1'b0;
            data_out       <= '0;
            gap_cnt        <= '0;
        end else begin
            data_valid_out <= issue;
            if (issue) begin
                data_out <= issue_data;
                gap_cnt  <= GAP_RELOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sos_input_scheduler.sv
// Scoreboard bench for sos_input_scheduler: directed stimulus, expected strobes queued with cycle stamps.
// Latency: checks the 2-cycle idle latency and exact MIN_GAP spacing.
// Backpressure: exercises full FIFO, flush and mid-stream reset.
module tb_sos_input_scheduler;
    import sos_pkg::*;

    localparam int DEPTH       = 8;
    localparam int MIN_GAP     = 16;
    localparam int SCALE_SHIFT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        data_valid_out;
    sos_sample_t data_out;
    logic [3:0]  level;
    logic        busy;

    sos_input_scheduler_if s_if ();

    sos_input_scheduler #(
        .DEPTH       (DEPTH),
        .MIN_GAP     (MIN_GAP),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_if           (s_if),
        .enable         (enable),
        .flush          (flush),
        .data_valid_out (data_valid_out),
        .data_out       (data_out),
        .level          (level),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected SOS input for a raw sample (shift of 1, round half up, when scaling is built in).
    function automatic logic [23:0] xf(logic [23:0] d);
`ifdef SOS_IN_SCALE_EN
        logic signed [24:0] t;
        t = $signed({d[23], d}) + 25'sd1;
        return t[24:1];
`else
        return d;
`endif
    endfunction

    // Monitor: every strobe must match the head of the scoreboard, in data and (when stamped) cycle.
    always @(negedge clk) begin
        if (data_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe (cycle %0d)", data_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_data", {8'h0, data_out}, {8'h0, e.data});
                if (e.at >= 0) check("strobe_cycle", cyc, e.at);
            end
        end
    end

    // Present one sample at a falling edge and hold it until accepted; acc is the accept edge number.
    task automatic push(input logic [23:0] d, output int acc);
        int b;
        b = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        #1;
        while (s_if.s_ready !== 1'b1 && b < 100) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (b >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got s_ready=%b, expected 1 within 100 cycles", s_if.s_ready);
        end
        acc = cyc + 1;
        @(negedge clk);
        s_if.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && b < 1000) begin
            @(negedge clk);
            b++;
        end
        check("idle_within_bound", (b < 1000) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    logic [23:0] pace_v [4] = '{24'h000011, 24'h000222, 24'h003334, 24'h044444};
    logic [23:0] rnd_in [4] = '{24'hFFFFFD, 24'h000003, 24'h7FFFFF, 24'h800000};
`ifdef SOS_IN_SCALE_EN
    logic [23:0] rnd_ex [4] = '{24'hFFFFFF, 24'h000002, 24'h400000, 24'hC00000};
`else
    logic [23:0] rnd_ex [4] = '{24'hFFFFFD, 24'h000003, 24'h7FFFFF, 24'h800000};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1);
    end

    initial begin
        int a;
        int c0;
        int n;
        int b;

        if (MIN_GAP < SOS_MULT_PIPE + 3) begin
            $display("FAIL min_gap_param: got %0d, expected at least %0d", MIN_GAP, SOS_MULT_PIPE + 3);
            $fatal(1);
        end

        rst_n        = 1'b0;
        enable       = 1'b1;
        flush        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, data_valid_out}, 32'd0);
        check("rst_data", {8'h0, data_out}, 32'd0);
        check("rst_level", {28'h0, level}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'h0, s_if.s_ready}, 32'd1);

        // Single sample: strobe two cycles after accept.
        c0 = cyc;
        sb.push_back(exp_t'{xf(24'h000100), c0 + 2});
        push(24'h000100, a);
        check("single_accept", a, c0 + 1);
        wait_idle();

        // Pacing: four back-to-back samples, strobes exactly MIN_GAP apart.
        c0 = cyc;
        for (int k = 0; k < 4; k++) sb.push_back(exp_t'{xf(pace_v[k]), c0 + 2 + MIN_GAP * k});
        for (int k = 0; k < 4; k++) begin
            push(pace_v[k], a);
            check("pace_accept", a, c0 + 1 + k);
        end
        wait_idle();

        // Full FIFO with issue disabled, ninth sample held upstream.
        enable = 1'b0;
        for (int k = 0; k < 8; k++) push(24'h010000 + 24'(k), a);
        #1;
        check("full_level", {28'h0, level}, 32'd8);
        check("full_ready", {31'h0, s_if.s_ready}, 32'd0);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 24'h0ABCDE;
        repeat (3) @(negedge clk);
        #1;
        check("full_hold_ready", {31'h0, s_if.s_ready}, 32'd0);
        check("full_hold_level", {28'h0, level}, 32'd8);
        n = cyc;
        for (int k = 0; k < 8; k++) sb.push_back(exp_t'{xf(24'h010000 + 24'(k)), n + 1 + MIN_GAP * k});
        sb.push_back(exp_t'{xf(24'h0ABCDE), n + 1 + MIN_GAP * 8});
        enable = 1'b1;
        b = 0;
        #1;
        while (s_if.s_ready !== 1'b1 && b < 50) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("ninth_ready_cycle", cyc, n + 1);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        check("ninth_level", {28'h0, level}, 32'd8);
        wait_idle();

        // Flush mid-stream: first issued, rest discarded, next issue waits out the gap.
        c0 = cyc;
        sb.push_back(exp_t'{xf(24'h020000), c0 + 2});
        for (int k = 0; k < 5; k++) push(24'h020000 + 24'(k), a);
        check("flush_pre_level", {28'h0, level}, 32'd4);
        flush = 1'b1;
        #1;
        check("flush_ready", {31'h0, s_if.s_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_level", {28'h0, level}, 32'd0);
        check("flush_busy_gap", {31'h0, busy}, 32'd1);
        sb.push_back(exp_t'{xf(24'h03FFFE), c0 + 2 + MIN_GAP});
        push(24'h03FFFE, a);
        wait_idle();

        // Rounding vectors through the scaler (pass-through when scaling is not built).
        for (int k = 0; k < 4; k++) sb.push_back(exp_t'{rnd_ex[k], -1});
        for (int k = 0; k < 4; k++) push(rnd_in[k], a);
        wait_idle();

        // Enable dropped mid-stream: resume one edge after re-enable once the gap has expired.
        c0 = cyc;
        sb.push_back(exp_t'{xf(24'h000123), c0 + 2});
        push(24'h000123, a);
        push(24'h000456, a);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("pause_level", {28'h0, level}, 32'd1);
        n = cyc;
        sb.push_back(exp_t'{xf(24'h000456), n + 1});
        enable = 1'b1;
        wait_idle();

        // Reset while samples are buffered and the gap counter is running.
        c0 = cyc;
        sb.push_back(exp_t'{xf(24'h055555), c0 + 2});
        push(24'h055555, a);
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) push(24'h066660 + 24'(k), a);
        check("mid_rst_pre_level", {28'h0, level}, 32'd3);
        check("mid_rst_pre_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'h0, data_valid_out}, 32'd0);
        check("mid_rst_data", {8'h0, data_out}, 32'd0);
        check("mid_rst_level", {28'h0, level}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_ready", {31'h0, s_if.s_ready}, 32'd1);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_level", {28'h0, level}, 32'd0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sos_input_scheduler.md
# sos_input_scheduler

Upstream pacing stage for the biquad (SOS) section. Accepts 24-bit signed samples over a ready/valid handshake, buffers them in a small FIFO, and issues them to the SOS `data_valid_in`/`data_in` port no more often than once every `MIN_GAP` cycles. This spacing lets each recursive state update (feedback multiply, 13-cycle pipeline) complete before the next sample enters. Optional input scaling provides headroom against the SOS internal saturation at ±4194303.

## Interface
- `DEPTH`, default 8: FIFO depth in samples; power of 2, ≥2.
- `MIN_GAP`, default 16: minimum cycles between issued samples; ≥1. Must be ≥ 13 (multiplier latency) + 3 for correct SOS recursion; the bench checks this, the RTL does not enforce it.
- `SCALE_SHIFT`, default 1: right-shift amount used when scaling is compiled in; range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: block can accept a sample.
- `s_data` in 24: signed two's-complement sample.
- `enable` in 1: issue permission. When low, samples are held in the FIFO and not issued.
- `flush` in 1: discard all buffered samples.
- `data_valid_out` out 1: one-cycle issue strobe to SOS `data_valid_in`.
- `data_out` out 24: signed sample to SOS `data_in`; held between strobes.
- `level` out `$clog2(DEPTH)+1`: current FIFO occupancy.
- `busy` out 1: high when `level != 0` or `gap_cnt != 0`.

## Operation
- Push:
  - A push occurs when `s_valid && s_ready`.
  - `s_ready = (level != DEPTH) && !flush`.
  - Full is evaluated on the registered `level` only. A pop in the same cycle does not free a slot for a push.
- Gap counter `gap_cnt`:
  - Loaded with `MIN_GAP-1` on every issue.
  - Otherwise decrements to 0 and saturates there.
  - Keeps counting while `enable` is low and during `flush`.
- Issue (pop) condition: `enable && level != 0 && gap_cnt == 0 && !flush`.
  - On issue, `data_out` is registered with the head sample (scaled if configured).
  - On issue, `data_valid_out` is high for exactly the next cycle.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Pointers:
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally at `DEPTH`.
  - `level` is tracked separately, not derived from the pointers.
- Flush:
  - On the next edge, pointers and `level` are set to 0.
  - No push and no issue occur in a flush cycle.
  - `gap_cnt` and `data_out` are unaffected, so an in-flight SOS sample stays protected.
- `enable` deasserted mid-stream: issue pauses. On re-enable, issue resumes as soon as `gap_cnt == 0`.
- Reset values when `rst_n` is sampled low at an edge:
  - `data_valid_out=0`, `data_out=0`.
  - `level=0`, pointers 0, `gap_cnt=0`.
  - `s_ready=1` from the following cycle, `busy=0`.
  - FIFO storage contents are don't-care.

## Timing
- Latency: a sample accepted at edge k into an empty FIFO, with `gap_cnt==0` and `enable` high, is issued at edge k+1. `data_valid_out` is high in the cycle after edge k+1, so latency is 2 cycles.
- Back-to-back issues: strobes are spaced exactly `MIN_GAP` cycles apart while the FIFO is non-empty.
- Sustained throughput: 1 sample per `MIN_GAP` cycles. An upstream source faster than this sees `s_ready` drop once `DEPTH` samples are buffered.
- `s_ready` depends only on registered state plus `flush`; there is no combinational path from `s_valid`.

## Configuration
- `SOS_IN_SCALE_EN` defined:
  - `data_out = (head + 2^(SCALE_SHIFT-1)) >>> SCALE_SHIFT`, computed in 25 bits (round half up).
  - The result always fits in 24 bits, so no saturation logic is needed.
- `SOS_IN_SCALE_EN` undefined: `data_out = head` (bit-exact pass-through). `SCALE_SHIFT` is ignored.

## Structure
- Shared package `sos_pkg`:
  - `SOS_DATA_W = 24`, `SOS_MULT_PIPE = 13`, `SOS_MIN_GAP_DEFAULT = 16`.
  - Typedef `sos_sample_t` (signed `[SOS_DATA_W-1:0]`).
- One sub-module, `sos_sync_fifo`: storage, pointers, `level`, push/pop/flush. The top level holds the gap counter, issue logic, scaling and output registers.

## Test plan
- Reset and single sample: `rst_n` low 3 cycles, then push `s_data=0x000100` → `data_valid_out` pulses once, 2 cycles after accept. `data_out = 0x000100`, or `0x000080` with `SOS_IN_SCALE_EN` and shift 1.
- Pacing: push 4 samples back-to-back with `MIN_GAP=16` → 4 strobes exactly 16 cycles apart, in order, with no strobe between them.
- Full and backpressure: `enable=0`, push 9 samples with `DEPTH=8` → `s_ready` low after the 8th, `level=8`, 9th held upstream. Set `enable=1` → 8 samples out in order; the 9th is accepted once `level` drops.
- Flush mid-stream: 5 buffered, first issued, `flush` pulsed for 1 cycle → `level=0` next cycle, no further strobes. The next strobe after a new push waits for `gap_cnt` to reach 0.
- Rounding (scale on, shift 1): inputs `-3`, `3`, `0x7FFFFF`, `0x800000` → `-1`, `2`, `0x400000`, `0xC00000`.
- Reset mid-operation: `rst_n` low while 3 samples are buffered and `gap_cnt != 0` → all outputs at reset values on the next cycle, no stale strobe afterward.
